// File: rtl/split_stim_gen.sv
// LFSR-driven assignment generator: fills NUM_VARS pseudo-random slots, offers
// them to an external checker, and tallies the checker's verdicts over MAX_ITER rounds.
module split_stim_gen #(
   parameter int          NUM_VARS = 150,
   parameter int          VAR_W    = 16,
   parameter logic [31:0] SEED     = 32'hACE1_2B3D,
   parameter logic [31:0] MAX_ITER = 32'd1024
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic                      asg_valid,
   output logic [NUM_VARS*VAR_W-1:0] asg_data,
   input  logic                      asg_ready,
   input  logic                      res_valid,
   input  logic                      res_x,
   output logic [31:0]               sat_count,
   output logic [31:0]               iter_count,
   output logic                      first_sat_found,
   output logic [31:0]               first_sat_idx
);

   // An all-zero Galois LFSR would lock up, so a zero seed is promoted to 1.
   localparam logic [31:0] SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
   localparam int          IDX_W     = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);

   typedef enum logic [2:0] {
      IDLE,
      GEN,
      PRESENT,
      WAIT_RES,
      DONE
   } state_t;

   state_t           state;
   logic [31:0]      lfsr;
   logic [31:0]      lfsr_next;
   logic [IDX_W-1:0] fill_idx;
   logic [31:0]      iter_inc;
   logic [31:0]      sat_inc;

   always_comb begin
      lfsr_next = {1'b0, lfsr[31:1]};
      if (lfsr[0]) begin
         lfsr_next = lfsr_next ^ LFSR_TAPS;
      end
   end

   // Counters stick at all-ones instead of wrapping.
   assign iter_inc = (iter_count == 32'hFFFF_FFFF) ? iter_count : iter_count + 32'd1;
   assign sat_inc  = (sat_count  == 32'hFFFF_FFFF) ? sat_count  : sat_count  + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         lfsr            <= SEED_EFF;
         fill_idx        <= '0;
         asg_data        <= '0;
         asg_valid       <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         sat_count       <= '0;
         iter_count      <= '0;
         first_sat_found <= 1'b0;
         first_sat_idx   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state           <= GEN;
                  busy            <= 1'b1;
                  fill_idx        <= '0;
                  sat_count       <= '0;
                  iter_count      <= '0;
                  first_sat_found <= 1'b0;
                  first_sat_idx   <= '0;
               end
            end

            GEN: begin
               lfsr <= lfsr_next;
               asg_data[int'(fill_idx)*VAR_W +: VAR_W] <= VAR_W'(lfsr_next);
               if (fill_idx == LAST_IDX) begin
                  state     <= PRESENT;
                  asg_valid <= 1'b1;
                  fill_idx  <= '0;
               end else begin
                  fill_idx <= fill_idx + IDX_W'(1);
               end
            end

            PRESENT: begin
               if (asg_ready) begin
                  state     <= WAIT_RES;
                  asg_valid <= 1'b0;
               end
            end

            // Verdicts are only looked at here, so a strobe that coincides with
            // the handshake cycle (still PRESENT) is dropped naturally.
            WAIT_RES: begin
               if (res_valid) begin
                  iter_count <= iter_inc;
                  if (res_x) begin
                     sat_count <= sat_inc;
                     if (!first_sat_found) begin
                        first_sat_found <= 1'b1;
                        first_sat_idx   <= iter_count;
                     end
                  end
                  if (iter_inc == MAX_ITER) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state    <= GEN;
                     fill_idx <= '0;
                  end
               end
            end

            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end

            default: begin
               state     <= IDLE;
               busy      <= 1'b0;
               done      <= 1'b0;
               asg_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_split_stim_gen.sv
// Randomised bench for split_stim_gen: two instances (seed 1 / 3 rounds, seed 0 / 1 round)
// checked against a queue-based reference of the LFSR and verdict tallies.
`timescale 1ns/1ps
module tb_split_stim_gen;

   localparam int          NV    = 4;
   localparam int          VW    = 8;
   localparam int          DW    = NV * VW;
   localparam logic [31:0] MAX_A = 32'd3;
   localparam logic [31:0] WORD1 = 32'h0301_0203;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start_a, asg_ready_a, res_valid_a, res_x_a;
   logic          busy_a, done_a, asg_valid_a, found_a;
   logic [DW-1:0] data_a;
   logic [31:0]   sat_a, iter_a, idx_a;
   logic          start_b, asg_ready_b, res_valid_b, res_x_b;
   logic          busy_b, done_b, asg_valid_b, found_b;
   logic [DW-1:0] data_b;
   logic [31:0]   sat_b, iter_b, idx_b;

   int            n_tests = 0;
   int            n_fail = 0;
   int            done_cnt_a = 0;
   int            done_cnt_b = 0;
   logic [31:0]   m_lfsr;
   logic [31:0]   g_iter, g_sat, g_idx;
   logic          g_found;
   logic [DW-1:0] g_word;

   split_stim_gen #(.NUM_VARS(NV), .VAR_W(VW), .SEED(32'd1), .MAX_ITER(MAX_A)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
      .asg_valid(asg_valid_a), .asg_data(data_a), .asg_ready(asg_ready_a),
      .res_valid(res_valid_a), .res_x(res_x_a), .sat_count(sat_a), .iter_count(iter_a),
      .first_sat_found(found_a), .first_sat_idx(idx_a)
   );

   split_stim_gen #(.NUM_VARS(NV), .VAR_W(VW), .SEED(32'd0), .MAX_ITER(32'd1)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .asg_valid(asg_valid_b), .asg_data(data_b), .asg_ready(asg_ready_b),
      .res_valid(res_valid_b), .res_x(res_x_b), .sat_count(sat_b), .iter_count(iter_b),
      .first_sat_found(found_b), .first_sat_idx(idx_b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (done_a === 1'b1) done_cnt_a++;
      if (done_b === 1'b1) done_cnt_b++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
   endfunction

   task automatic model_word(output logic [DW-1:0] w);
      w = '0;
      for (int i = 0; i < NV; i++) begin
         m_lfsr = lfsr_step(m_lfsr);
         w[i*VW +: VW] = m_lfsr[VW-1:0];
      end
   endtask

   // Expected end-of-run tallies straight from the list of verdicts given.
   task automatic model_summary(input bit q[$], output logic [31:0] e_iter,
                                output logic [31:0] e_sat, output logic e_found,
                                output logic [31:0] e_idx);
      e_iter  = 32'(q.size());
      e_sat   = '0;
      e_found = 1'b0;
      e_idx   = '0;
      foreach (q[i]) begin
         if (q[i]) begin
            e_sat++;
            if (!e_found) begin
               e_found = 1'b1;
               e_idx   = 32'(i);
            end
         end
      end
   endtask

   task automatic start_run_a();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
   endtask

   task automatic accept_a(input int delay);
      repeat (delay) @(negedge clk);
      asg_ready_a = 1'b1;
      @(negedge clk);
      asg_ready_a = 1'b0;
   endtask

   task automatic verdict_a(input bit x, input int delay);
      repeat (delay) @(negedge clk);
      res_valid_a = 1'b1;
      res_x_a     = x;
      @(negedge clk);
      res_valid_a = 1'b0;
      res_x_a     = 1'b0;
   endtask

   task automatic one_iter_a(input bit x, input int rdly, input int vdly,
                             output logic [DW-1:0] seen, output bit timeout);
      seen    = '0;
      timeout = 1'b1;
      for (int i = 0; i < 40 && timeout; i++) begin
         @(negedge clk);
         if (asg_valid_a === 1'b1) timeout = 1'b0;
      end
      if (!timeout) begin
         seen = data_a;
         accept_a(rdly);
         verdict_a(x, vdly);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      {start_a, asg_ready_a, res_valid_a, res_x_a} = '0;
      {start_b, asg_ready_b, res_valid_b, res_x_b} = '0;
      #1 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({busy_a, done_a, asg_valid_a, found_a, data_a, sat_a, iter_a, idx_a} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_async_a: got %h expected 0",
                  {busy_a, done_a, asg_valid_a, found_a, data_a, sat_a, iter_a, idx_a});
      end
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if ({busy_b, done_b, asg_valid_b, found_b, data_b, sat_b, iter_b, idx_b} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_b: got %h expected 0",
                  {busy_b, done_b, asg_valid_b, found_b, data_b, sat_b, iter_b, idx_b});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_first_run();
      bit            vq[$];
      logic [DW-1:0] seen, exp;
      logic [31:0]   e_iter, e_sat, e_idx;
      logic          e_found;
      bit            to;
      int            d0;
      vq     = '{1'b0, 1'b1, 1'b1};
      m_lfsr = 32'd1;
      d0     = done_cnt_a;
      start_run_a();
      n_tests++;
      if (busy_a !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL start_after_reset: busy got %b expected 1", busy_a);
      end
      foreach (vq[i]) begin
         one_iter_a(vq[i], 0, 0, seen, to);
         model_word(exp);
         n_tests++;
         if (to || seen !== exp) begin
            n_fail++;
            $display("[TB] FAIL first_run_word%0d: got %h expected %h (timeout=%0b)", i, seen, exp, to);
         end
         if (i == 0) begin
            n_tests++;
            if (seen !== WORD1) begin
               n_fail++;
               $display("[TB] FAIL first_word_seed1: got %h expected %h", seen, WORD1);
            end
         end
      end
      n_tests++;
      if ({done_a, busy_a} !== 2'b11) begin
         n_fail++;
         $display("[TB] FAIL done_pulse: got done,busy=%b expected 11", {done_a, busy_a});
      end
      @(negedge clk);
      n_tests++;
      if ({done_a, busy_a} !== 2'b00) begin
         n_fail++;
         $display("[TB] FAIL after_done: got done,busy=%b expected 00", {done_a, busy_a});
      end
      model_summary(vq, e_iter, e_sat, e_found, e_idx);
      n_tests++;
      if ({iter_a, sat_a, found_a, idx_a} !== {e_iter, e_sat, e_found, e_idx}) begin
         n_fail++;
         $display("[TB] FAIL first_run_counts: got %0d/%0d/%0b/%0d expected %0d/%0d/%0b/%0d",
                  iter_a, sat_a, found_a, idx_a, e_iter, e_sat, e_found, e_idx);
      end
      @(negedge clk);
      n_tests++;
      if (done_cnt_a - d0 !== 1) begin
         n_fail++;
         $display("[TB] FAIL done_count_run1: got %0d expected 1", done_cnt_a - d0);
      end
      n_tests++;
      if (data_a !== exp) begin
         n_fail++;
         $display("[TB] FAIL data_hold_idle: got %h expected %h", data_a, exp);
      end
   endtask

   task automatic test_stall_and_ignored();
      bit            vq[$];
      logic [DW-1:0] seen, exp;
      logic [31:0]   e_iter, e_sat, e_idx;
      logic          e_found;
      bit            to, x;
      start_run_a();
      n_tests++;
      if ({iter_a, sat_a, found_a, idx_a} !== '0) begin
         n_fail++;
         $display("[TB] FAIL clear_on_start: got %h expected 0", {iter_a, sat_a, found_a, idx_a});
      end
      start_a = 1'b1; res_valid_a = 1'b1; res_x_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0; res_valid_a = 1'b0; res_x_a = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 40 && to; i++) begin
         if (asg_valid_a === 1'b1) to = 1'b0;
         else @(negedge clk);
      end
      model_word(exp);
      n_tests++;
      if (to || data_a !== exp) begin
         n_fail++;
         $display("[TB] FAIL gen_ignores_start: got %h expected %h (timeout=%0b)", data_a, exp, to);
      end
      for (int k = 0; k < 10; k++) begin
         res_valid_a = (k == 3);
         res_x_a     = 1'b1;
         start_a     = (k == 5);
         @(negedge clk);
         n_tests++;
         if (asg_valid_a !== 1'b1 || data_a !== exp) begin
            n_fail++;
            $display("[TB] FAIL stall_cycle%0d: got valid=%b data=%h expected valid=1 data=%h",
                     k, asg_valid_a, data_a, exp);
         end
      end
      start_a = 1'b0;
      asg_ready_a = 1'b1; res_valid_a = 1'b1; res_x_a = 1'b1;
      @(negedge clk);
      asg_ready_a = 1'b0; res_valid_a = 1'b0; res_x_a = 1'b0;
      n_tests++;
      if ({asg_valid_a, busy_a, iter_a, sat_a} !== {1'b0, 1'b1, 64'd0}) begin
         n_fail++;
         $display("[TB] FAIL handshake_ignores_res: got valid=%b busy=%b iter=%0d sat=%0d expected 0/1/0/0",
                  asg_valid_a, busy_a, iter_a, sat_a);
      end
      x = 1'($urandom);
      vq.push_back(x);
      verdict_a(x, 1);
      for (int i = 1; i < 3; i++) begin
         x = 1'($urandom);
         vq.push_back(x);
         one_iter_a(x, $urandom_range(0, 3), $urandom_range(0, 3), seen, to);
         model_word(exp);
         n_tests++;
         if (to || seen !== exp) begin
            n_fail++;
            $display("[TB] FAIL stall_run_word%0d: got %h expected %h (timeout=%0b)", i, seen, exp, to);
         end
      end
      @(negedge clk);
      model_summary(vq, e_iter, e_sat, e_found, e_idx);
      n_tests++;
      if ({iter_a, sat_a, found_a, idx_a, busy_a} !== {e_iter, e_sat, e_found, e_idx, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL stall_run_counts: got %0d/%0d/%0b/%0d busy=%b expected %0d/%0d/%0b/%0d busy=0",
                  iter_a, sat_a, found_a, idx_a, busy_a, e_iter, e_sat, e_found, e_idx);
      end
   endtask

   task automatic test_random_runs();
      bit            vq[$];
      logic [DW-1:0] seen, exp;
      logic [31:0]   e_iter, e_sat, e_idx;
      logic          e_found;
      bit            to, x;
      int            d0;
      for (int r = 0; r < 4; r++) begin
         vq.delete();
         d0 = done_cnt_a;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         start_run_a();
         for (int i = 0; i < 3; i++) begin
            x = 1'($urandom);
            vq.push_back(x);
            one_iter_a(x, $urandom_range(0, 3), $urandom_range(0, 3), seen, to);
            model_word(exp);
            n_tests++;
            if (to || seen !== exp) begin
               n_fail++;
               $display("[TB] FAIL rand_run%0d_word%0d: got %h expected %h (timeout=%0b)", r, i, seen, exp, to);
            end
         end
         @(negedge clk);
         @(negedge clk);
         model_summary(vq, e_iter, e_sat, e_found, e_idx);
         n_tests++;
         if ({iter_a, sat_a, found_a, idx_a} !== {e_iter, e_sat, e_found, e_idx}
             || done_cnt_a - d0 !== 1) begin
            n_fail++;
            $display("[TB] FAIL rand_run%0d_counts: got %0d/%0d/%0b/%0d done=%0d expected %0d/%0d/%0b/%0d done=1",
                     r, iter_a, sat_a, found_a, idx_a, done_cnt_a - d0, e_iter, e_sat, e_found, e_idx);
         end
      end
   endtask

   task automatic test_reset_midrun();
      bit            vq[$];
      logic [DW-1:0] seen, exp;
      logic [31:0]   e_iter, e_sat, e_idx;
      logic          e_found;
      bit            to, x;
      int            d0;
      start_run_a();
      to = 1'b1;
      for (int i = 0; i < 40 && to; i++) begin
         @(negedge clk);
         if (asg_valid_a === 1'b1) to = 1'b0;
      end
      accept_a(0);
      res_valid_a = 1'b0;
      d0 = done_cnt_a;
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (to || {busy_a, done_a, asg_valid_a, found_a, data_a, sat_a, iter_a, idx_a} !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_midrun: got %h expected 0 (timeout=%0b)",
                  {busy_a, done_a, asg_valid_a, found_a, data_a, sat_a, iter_a, idx_a}, to);
      end
      @(negedge clk);
      @(negedge clk);
      rst_n  = 1'b1;
      m_lfsr = 32'd1;
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (done_cnt_a !== d0 || busy_a !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL no_done_after_reset: got pulses=%0d busy=%b expected 0/0", done_cnt_a - d0, busy_a);
      end
      start_run_a();
      for (int i = 0; i < 3; i++) begin
         x = 1'($urandom);
         vq.push_back(x);
         one_iter_a(x, $urandom_range(0, 2), $urandom_range(0, 2), seen, to);
         model_word(exp);
         n_tests++;
         if (to || seen !== exp || (i == 0 && seen !== WORD1)) begin
            n_fail++;
            $display("[TB] FAIL reseed_word%0d: got %h expected %h (timeout=%0b)", i, seen, exp, to);
         end
      end
      @(negedge clk);
      model_summary(vq, g_iter, g_sat, g_found, g_idx);
      g_word = exp;
      n_tests++;
      if ({iter_a, sat_a, found_a, idx_a} !== {g_iter, g_sat, g_found, g_idx}) begin
         n_fail++;
         $display("[TB] FAIL reseed_run_counts: got %0d/%0d/%0b/%0d expected %0d/%0d/%0b/%0d",
                  iter_a, sat_a, found_a, idx_a, g_iter, g_sat, g_found, g_idx);
      end
   endtask

   task automatic test_seed_zero();
      logic [31:0] exp;
      bit          to;
      int          d0;
      exp = '0;
      m_lfsr = 32'd1;
      for (int i = 0; i < NV; i++) begin
         m_lfsr = lfsr_step(m_lfsr);
         exp[i*VW +: VW] = m_lfsr[VW-1:0];
      end
      d0 = done_cnt_b;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 40 && to; i++) begin
         @(negedge clk);
         if (asg_valid_b === 1'b1) to = 1'b0;
      end
      n_tests++;
      if (to || data_b !== exp || data_b !== WORD1) begin
         n_fail++;
         $display("[TB] FAIL seed_zero_word: got %h expected %h (timeout=%0b)", data_b, exp, to);
      end
      asg_ready_b = 1'b1;
      @(negedge clk);
      asg_ready_b = 1'b0;
      res_valid_b = 1'b1;
      res_x_b     = 1'b1;
      @(negedge clk);
      res_valid_b = 1'b0;
      res_x_b     = 1'b0;
      n_tests++;
      if (done_b !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL max1_done: got %b expected 1", done_b);
      end
      @(negedge clk);
      @(negedge clk);
      n_tests++;
      if ({iter_b, sat_b, found_b, idx_b, busy_b} !== {32'd1, 32'd1, 1'b1, 32'd0, 1'b0}
          || done_cnt_b - d0 !== 1) begin
         n_fail++;
         $display("[TB] FAIL max1_counts: got %0d/%0d/%0b/%0d busy=%b done=%0d expected 1/1/1/0 busy=0 done=1",
                  iter_b, sat_b, found_b, idx_b, busy_b, done_cnt_b - d0);
      end
   endtask

   task automatic test_idle_ignores();
      res_valid_a = 1'b1;
      res_x_a     = 1'b1;
      asg_ready_a = 1'b1;
      repeat (3) @(negedge clk);
      res_valid_a = 1'b0;
      res_x_a     = 1'b0;
      asg_ready_a = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({iter_a, sat_a, found_a, idx_a, busy_a, asg_valid_a, data_a}
          !== {g_iter, g_sat, g_found, g_idx, 1'b0, 1'b0, g_word}) begin
         n_fail++;
         $display("[TB] FAIL idle_ignores_res: got %0d/%0d/%0b/%0d busy=%b valid=%b data=%h expected %0d/%0d/%0b/%0d busy=0 valid=0 data=%h",
                  iter_a, sat_a, found_a, idx_a, busy_a, asg_valid_a, data_a,
                  g_iter, g_sat, g_found, g_idx, g_word);
      end
   endtask

   initial begin
      test_reset();
      test_first_run();
      test_stall_and_ignored();
      test_random_runs();
      test_reset_midrun();
      test_seed_zero();
      test_idle_ignores();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
